uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Synthesizable UART receiver that deserialises the asynchronous line into parallel words for the FPGA fabric. It sits behind the board `uart_rx_pin` inside the test harness top level and feeds received bytes to the loopback/delay-line datapath over a valid/ready handshake. It is fixed-baud and 8N1 by default, and samples mid-bit from a free-running system clock.

## Interface
- `CLK_RATE`, 12_000_000, system clock frequency in Hz
- `BAUD`, 9600, line bit rate; `CLKS_PER_BAUD = CLK_RATE / BAUD` (integer division, 1250 at defaults)
- `DATA_WIDTH`, 8, data bits per frame, LSB first, range 5–9
- `STOP_BITS`, 1, stop bits checked per frame, range 1–2

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `uart_rx_pin`  in  1  raw asynchronous serial line, idle high
- `m_data`  out  DATA_WIDTH  received word, stable while `m_valid` is high
- `m_valid`  out  1  word available
- `m_ready`  in  1  consumer accepts the word when high with `m_valid`
- `framing_err`  out  1  one-cycle pulse: a stop bit was sampled low
- `overrun_err`  out  1  one-cycle pulse: a word completed while the output was still full
- `busy`  out  1  high in any state other than IDLE/ARM

## Operation
- 2-FF synchroniser on `uart_rx_pin`; both flops reset to 1. All decisions use the synchronised value `rx_s`.
- FSM states:
  - ARM: reset state; wait for `rx_s`==1, then go to IDLE.
  - IDLE: `rx_s`==0 → START; load the bit timer with `CLKS_PER_BAUD/2`. This is cycle T0.
  - START: at timer expiry, sample. 0 → DATA with the timer reloaded to `CLKS_PER_BAUD`. 1 → IDLE (false start, no output, no error).
  - DATA: sample at each expiry, shift LSB first. After `DATA_WIDTH` samples → STOP.
  - STOP: sample each stop bit.
    - Any stop bit 0 → pulse `framing_err`, discard the word, go to ARM (waits out a break).
    - All stop bits 1 → deliver the word, go to IDLE.
- Sample instants: start at T0+`CLKS_PER_BAUD/2`; data bit i at T0+`CLKS_PER_BAUD/2`+(i+1)·`CLKS_PER_BAUD`; stop bit j at T0+`CLKS_PER_BAUD/2`+(`DATA_WIDTH`+1+j)·`CLKS_PER_BAUD`.
- Output register, one-deep:
  - Delivery when empty, or when `m_ready` is high in the same cycle: load `m_data`, set `m_valid`.
  - Delivery when `m_valid`=1 and `m_ready`=0: keep the old word, drop the new one, pulse `overrun_err`.
  - `m_valid` clears on a `m_valid && m_ready` cycle with no simultaneous delivery.
- Bit timer width is `$clog2(CLKS_PER_BAUD+1)`; it never wraps and reloads only on expiry or state entry.

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `framing_err`=0, `overrun_err`=0, `busy`=0; state ARM.
- Pin-to-T0 latency: 2–3 clocks (synchroniser plus edge).
- `m_valid` rises on the clock after the final stop-bit sample. This is mid-final-stop-bit, about `(DATA_WIDTH+STOP_BITS+0.5)·CLKS_PER_BAUD` + 3 clocks after the pin start edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge arriving as early as the nominal end of the stop bit is caught. Sender baud error of ±3 % is tolerated at defaults.
- Error pulses are exactly one cycle wide and coincide with the cycle the word would have been loaded.
- Reset asserted mid-frame aborts immediately. After release the block stays in ARM while the line is low, so a partial frame is never decoded.
- `m_ready` is ignored while `m_valid`=0. `m_data` is not updated by an accepted handshake alone.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample is the 2-of-3 majority of `rx_s` at instants t−1, t and t+1 around each nominal instant t.
  - The decision is taken at t+1, so all sample instants and `m_valid` are 1 clock later.
  - A single-cycle glitch at a sample point is rejected.
- Not defined: a single sample at t; no extra latency.

## Test plan
- Defaults, `m_ready`=1, send 0x00, 0xFF, then 0xA5 with a 100 µs gap → three `m_valid` pulses with `m_data` 0x00, 0xFF, 0xA5; no error pulses.
- `m_ready`=0, send 0x12 then 0x34 → `m_data` holds 0x12, one `overrun_err` pulse. Then raise `m_ready` → 0x12 accepted, `m_valid` falls.
- Send 0x5A with the stop bit driven 0, line held low for 2 bit times, then high, then 0x3C → one `framing_err`, no word for 0x5A, 0x3C received.
- Line pulses low for 100 clocks (< `CLKS_PER_BAUD/2`) → no `m_valid`, no error, `busy` returns low within 626 clocks.
- Assert `rst` during data bit 3 of 0xC3 with the line low at release, then complete the frame and send 0x81 → only 0x81 is received.
- Sender at BAUD·1.03 and BAUD·0.97, 100 random bytes each → all bytes match, no errors; repeat with `UART_RX_MAJORITY_EN`.

Source files
------------

// File: rtl/uart_rx_core.sv
// Fixed-baud UART receiver (8N1 by default) with a one-deep valid/ready output register.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the nominal sample point.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int CLK_RATE   = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  uart_rx_pin,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  framing_err,
    output logic                  overrun_err,
    output logic                  busy
);
    localparam int CLKS_PER_BAUD = CLK_RATE / BAUD;
    localparam int TW            = $clog2(CLKS_PER_BAUD + 1);

    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BAUD);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal instant, so every decision lands one clock later.
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BAUD / 2 + 1);
`else
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BAUD / 2);
`endif
    localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {ARM, IDLE, START, DATA, STOP} state_t;

    state_t                state, next_state;
    logic [TW-1:0]         timer, timer_val;
    logic [3:0]            bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic                  rx_meta, rx_s, sample_bit, tick;
    logic [1:0]            sync_fill;
    logic                  timer_load, cnt_clr, cnt_inc, shift_en, deliver, frame_bad;

    // sync_fill marks when rx_s reflects the real pin rather than its reset value,
    // so ARM cannot mistake a line held low across reset for an idle line.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            rx_meta   <= uart_rx_pin;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_h1, rx_h2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_h1 <= 1'b1;
            rx_h2 <= 1'b1;
        end else begin
            rx_h1 <= rx_s;
            rx_h2 <= rx_h1;
        end
    end

    assign sample_bit = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
    assign sample_bit = rx_s;
`endif

    assign tick = (timer == TW'(1));
    assign busy = (state != ARM) && (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARM;
            timer   <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state <= next_state;
            if (timer_load)
                timer <= timer_val;
            else if (timer != '0)
                timer <= timer - TW'(1);
            if (cnt_clr)
                bit_cnt <= '0;
            else if (cnt_inc)
                bit_cnt <= bit_cnt + 4'd1;
            if (shift_en)
                shift <= {sample_bit, shift[DATA_WIDTH-1:1]};
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        timer_val  = FULL_LOAD;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            ARM: begin
                if (sync_fill[1] && rx_s)
                    next_state = IDLE;
            end
            IDLE: begin
                if (!rx_s) begin
                    next_state = START;
                    timer_load = 1'b1;
                    timer_val  = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (!sample_bit) begin
                        next_state = DATA;
                        timer_load = 1'b1;
                        cnt_clr    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en   = 1'b1;
                    timer_load = 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        next_state = STOP;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (!sample_bit) begin
                        frame_bad  = 1'b1;
                        next_state = ARM;
                    end else if (bit_cnt == LAST_STOP) begin
                        deliver    = 1'b1;
                        next_state = IDLE;
                    end else begin
                        cnt_inc    = 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            default: next_state = ARM;
        endcase
    end

    // A full register that is not being drained keeps its word; the new one is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data      <= '0;
            m_valid     <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun_err <= deliver && m_valid && !m_ready;
            if (deliver && (!m_valid || m_ready)) begin
                m_data  <= shift;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 32 clocks per bit: frame table plus overrun, glitch,
// mid-frame reset, latency and +/-3 % baud sequences.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int  CLK_RATE = 307_200;
    localparam int  BAUD     = 9600;
    localparam int  CPB      = CLK_RATE / BAUD;
    localparam real CLK_NS   = 10.0;
    localparam real BIT_NS   = CPB * CLK_NS;
`ifdef UART_RX_MAJORITY_EN
    localparam int EXP_LAT = 9 * CPB + CPB / 2 + 4;
`else
    localparam int EXP_LAT = 9 * CPB + CPB / 2 + 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       framing_err, overrun_err, busy;

    uart_rx_core #(.CLK_RATE(CLK_RATE), .BAUD(BAUD), .DATA_WIDTH(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .uart_rx_pin(pin), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .framing_err(framing_err), .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0, oerr_cnt = 0, wide_cnt = 0;
    logic       ferr_prev = 1'b0, oerr_prev = 1'b0;

    // m_ready only changes just after a rising edge, so the pair seen here is the one accepted next edge.
    always @(negedge clk) begin
        if (m_valid && m_ready) rx_q.push_back(m_data);
        if (framing_err) ferr_cnt++;
        if (overrun_err) oerr_cnt++;
        if ((framing_err && ferr_prev) || (overrun_err && oerr_prev)) wide_cnt++;
        ferr_prev = framing_err;
        oerr_prev = overrun_err;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input real bit_ns,
                              input int low_bits, input int gap_bits);
        pin = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            pin = d[i];
            #(bit_ns);
        end
        pin = stop_v;
        #(bit_ns);
        if (low_bits > 0) begin
            pin = 1'b0;
            #(bit_ns * low_bits);
        end
        pin = 1'b1;
        #(bit_ns * gap_bits);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         low_bits;
        int         gap_bits;
        logic       exp_word;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int   n0, f0, o0, cnt;
        logic seen;

        vecs[0] = '{8'h00, 1'b1, 0, 1, 1'b1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 0, 1, 1'b1, 8'hFF, 0};
        vecs[2] = '{8'hA5, 1'b1, 0, 4, 1'b1, 8'hA5, 0};
        vecs[3] = '{8'h5A, 1'b0, 2, 2, 1'b0, 8'h00, 1};
        vecs[4] = '{8'h3C, 1'b1, 0, 1, 1'b1, 8'h3C, 0};
        vecs[5] = '{8'h01, 1'b1, 0, 1, 1'b1, 8'h01, 0};
        vecs[6] = '{8'h80, 1'b1, 0, 1, 1'b1, 8'h80, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_framing_err", 32'(framing_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Frame table
        for (int v = 0; v < 7; v++) begin
            n0 = rx_q.size();
            f0 = ferr_cnt;
            o0 = oerr_cnt;
            @(negedge clk);
            send_frame(vecs[v].data, vecs[v].stop_bit, BIT_NS, vecs[v].low_bits, vecs[v].gap_bits);
            check($sformatf("vec%0d_word_count", v), 32'(rx_q.size() - n0), 32'(vecs[v].exp_word));
            if (vecs[v].exp_word && rx_q.size() > n0)
                check($sformatf("vec%0d_data", v), 32'(rx_q[rx_q.size()-1]), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d_framing", v), 32'(ferr_cnt - f0), 32'(vecs[v].exp_ferr));
            check($sformatf("vec%0d_overrun", v), 32'(oerr_cnt - o0), 32'd0);
        end

        // Start edge to m_valid latency
        n0 = rx_q.size();
        cnt = 0;
        @(negedge clk);
        fork
            send_frame(8'h96, 1'b1, BIT_NS, 0, 1);
            begin
                while (!m_valid && cnt < 1000) begin
                    @(negedge clk);
                    cnt++;
                end
            end
        join
        check("latency_clocks", 32'(cnt), 32'(EXP_LAT));
        check("latency_data", (rx_q.size() > n0) ? 32'(rx_q[rx_q.size()-1]) : 32'hDEAD, 32'h96);

        // Overrun with the consumer stalled
        @(posedge clk);
        #1 m_ready = 1'b0;
        o0 = oerr_cnt;
        n0 = rx_q.size();
        @(negedge clk);
        send_frame(8'h12, 1'b1, BIT_NS, 0, 1);
        check("ovr_valid_first", 32'(m_valid), 32'd1);
        check("ovr_data_first", 32'(m_data), 32'h12);
        send_frame(8'h34, 1'b1, BIT_NS, 0, 1);
        check("ovr_pulses", 32'(oerr_cnt - o0), 32'd1);
        check("ovr_data_kept", 32'(m_data), 32'h12);
        @(posedge clk);
        #1 m_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("ovr_valid_falls", 32'(m_valid), 32'd0);
        check("ovr_data_after_accept", 32'(m_data), 32'h12);
        check("ovr_accepted_count", 32'(rx_q.size() - n0), 32'd1);
        check("ovr_accepted_word", (rx_q.size() > n0) ? 32'(rx_q[rx_q.size()-1]) : 32'hDEAD, 32'h12);

        // Short low glitch is a false start
        n0 = rx_q.size();
        f0 = ferr_cnt;
        o0 = oerr_cnt;
        seen = 1'b0;
        @(negedge clk);
        pin = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        pin = 1'b1;
        cnt = 0;
        while ((busy || !seen) && cnt < CPB / 2 + 8) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            cnt++;
        end
        check("glitch_busy_seen", 32'(seen), 32'd1);
        check("glitch_busy_low", 32'(busy), 32'd0);
        repeat (2 * CPB) @(negedge clk);
        check("glitch_no_word", 32'(rx_q.size() - n0), 32'd0);
        check("glitch_no_err", 32'(ferr_cnt - f0 + oerr_cnt - o0), 32'd0);

        // Reset during data bit 3 of 0xC3, line still low at release
        n0 = rx_q.size();
        f0 = ferr_cnt;
        @(negedge clk);
        fork
            send_frame(8'hC3, 1'b1, BIT_NS, 0, 2);
            begin
                #(4.5 * BIT_NS);
                rst = 1'b1;
                #(3 * CLK_NS);
                check("mid_rst_valid", 32'(m_valid), 32'd0);
                rst = 1'b0;
                #(20 * CLK_NS);
                check("mid_rst_armed_busy", 32'(busy), 32'd0);
            end
        join
        @(negedge clk);
        send_frame(8'h81, 1'b1, BIT_NS, 0, 1);
        check("mid_rst_word_count", 32'(rx_q.size() - n0), 32'd1);
        check("mid_rst_word", (rx_q.size() > n0) ? 32'(rx_q[rx_q.size()-1]) : 32'hDEAD, 32'h81);
        check("mid_rst_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Back-to-back random bytes at +3 % and -3 % sender baud
        for (int s = 0; s < 2; s++) begin
            real bns;
            bns = (s == 0) ? BIT_NS / 1.03 : BIT_NS / 0.97;
            rx_q.delete();
            exp_q.delete();
            f0 = ferr_cnt;
            o0 = oerr_cnt;
            for (int i = 0; i < 24; i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                send_frame(b, 1'b1, bns, 0, 0);
            end
            #(2 * BIT_NS);
            check($sformatf("baud%0d_count", s), 32'(rx_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("baud%0d_byte%0d", s, i),
                      (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD, 32'(exp_q[i]));
            check($sformatf("baud%0d_errors", s), 32'(ferr_cnt - f0 + oerr_cnt - o0), 32'd0);
        end

        check("error_pulse_width", 32'(wide_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
